bcd_countdown_2digit: RTL and testbench
=======================================

Name: bcd_countdown_2digit

Overview:
- Two-digit BCD down-counter/timer, the counting counterpart of the team's one-digit BCD up-counter.
- Loads a preset of 00..99 and decrements once per enable tick.
- Signals expiry with a one-cycle Done pulse, then holds at 00 or, optionally, reloads.
- Feeds the 7-segment display path and the timer-expiry logic in the lab top level.

Parameters:
AUTO_RELOAD  0  1 = on the first En tick after expiry, reload the last preset and keep counting; 0 = hold at 00 until the next Load.

Ports:
Clk      input   1  system clock; all state changes on its rising edge
R        input   1  reset, synchronous, active-high
Load     input   1  capture Din as the preset and start counting
Din      input   8  preset in BCD, {tens[7:4], ones[3:0]}
En       input   1  count-enable tick; one decrement per cycle it is high in RUN
O_tens   output  4  tens digit, BCD 0..9
O_ones   output  4  ones digit, BCD 0..9
Running  output  1  high while state = RUN
Zero     output  1  high when {O_tens,O_ones} = 00, decoded from registers
Done     output  1  registered one-cycle expiry pulse

Behaviour:
- States: IDLE, RUN, EXPIRED.
- Internal registers: count (2 digits), preset (2 digits), state, Done.
- Priority each cycle: R > Load > En.
- Reset (R=1 at the clock edge): state=IDLE, count=00, preset=00, Done=0. Next cycle: Running=0, Zero=1. Reset mid-count aborts with no Done pulse.
- Input clamping: on Load, any Din digit greater than 9 is clamped to 9, per digit. Example: Din=0xA3 loads 93.
- Load=1 (any state, R=0): count and preset take the clamped Din.
  - Clamped value nonzero: state goes to RUN.
  - Clamped value 00: state goes to IDLE.
  - En in the same cycle is ignored. Done=0 that cycle.
- IDLE: En is ignored; count holds.
- RUN with En=1, normal decrement:
  - ones is not 0: ones = ones-1.
  - ones is 0: ones = 9 and tens = tens-1.
  - Latency: the new value is visible on the cycle after the edge.
- RUN with En=1 and count=01: count becomes 00, state goes to EXPIRED, Done=1 for exactly the next cycle (the same cycle O first shows 00).
- RUN with En=0: count holds.
- EXPIRED with En=1:
  - AUTO_RELOAD=0: count holds at 00, no further Done.
  - AUTO_RELOAD=1: count = preset, state goes to RUN. The preset is always nonzero in this case. That tick is not a decrement.
- EXPIRED with En=0: hold.
- Done is cleared in every cycle except the one following the 01 to 00 transition.
- Counting never wraps below 00. The only path from 00 back to a nonzero value is Load or an auto-reload.
- Outputs are always valid BCD.
- All outputs are driven directly from registers, except Zero and Running, which are a simple decode of registers. No combinational path from any input to any output.

Test Plan:
- Reset then idle: R=1 for 2 cycles, then En=1 for 5 cycles with no Load -> O=00, Zero=1, Running=0, Done never asserted.
- Basic countdown: Load Din=0x12, then En=1 continuously -> O steps 12,11,10,09,...,01,00. Borrow 10->09 occurs on the 3rd tick. Done=1 exactly in the cycle O=00 (12th tick). Running falls with it. Further En holds 00 (AUTO_RELOAD=0).
- Clamping and priority: Din=0xAF with Load=1 and En=1 in the same cycle -> O=99 with no decrement that cycle. Next En gives 98. Load Din=0x00 -> O=00, state IDLE, no Done.
- Gapped enables and reset abort: load 05, pulse En every 3rd cycle -> count changes only on En cycles. Assert R when O=03 -> next cycle O=00, Done=0, Running=0.
- Reload mid-run and auto-reload: load 20, 4 ticks (O=16), then Load 0x03 -> O=03, RUN. With AUTO_RELOAD=1, 3 ticks -> 00 with Done pulse; next En -> O=03, Running=1, no Done.
- Random check against a reference model: 1000 cycles of random Load/Din/En/R -> O, Zero, Running and Done match the model every cycle, O always BCD, and Done is never high on two consecutive cycles.

Source files
------------

// File: rtl/bcd_countdown_2digit.sv
// Two-digit BCD down-counter/timer with one-cycle expiry pulse.
// Ports: Clk, R (sync reset), Load/Din (BCD preset), En (tick);
//        O_tens/O_ones (count), Running, Zero, Done (expiry pulse).
module bcd_countdown_2digit #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       Clk,
    input  logic       R,
    input  logic       Load,
    input  logic [7:0] Din,
    input  logic       En,
    output logic [3:0] O_tens,
    output logic [3:0] O_ones,
    output logic       Running,
    output logic       Zero,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] tens, tens_n;
    logic [3:0] ones, ones_n;
    logic [3:0] pre_t, pre_t_n;
    logic [3:0] pre_o, pre_o_n;
    logic       done, done_n;
    logic [3:0] din_t, din_o;
    logic       din_zero;
    logic       at_one;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign din_t    = clamp9(Din[7:4]);
    assign din_o    = clamp9(Din[3:0]);
    assign din_zero = (din_t == 4'd0) && (din_o == 4'd0);
    assign at_one   = (tens == 4'd0) && (ones == 4'd1);

    always_ff @(posedge Clk) begin
        if (R) begin
            state <= IDLE;
            tens  <= 4'd0;
            ones  <= 4'd0;
            pre_t <= 4'd0;
            pre_o <= 4'd0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            tens  <= tens_n;
            ones  <= ones_n;
            pre_t <= pre_t_n;
            pre_o <= pre_o_n;
            done  <= done_n;
        end
    end

    // Load outranks En; arms are kept mutually exclusive
    // so the unique decode never sees two true items.
    always_comb begin
        state_n = state;
        tens_n  = tens;
        ones_n  = ones;
        pre_t_n = pre_t;
        pre_o_n = pre_o;
        done_n  = 1'b0;
        unique case (1'b1)
            Load: begin
                tens_n  = din_t;
                ones_n  = din_o;
                pre_t_n = din_t;
                pre_o_n = din_o;
                state_n = din_zero ? IDLE : RUN;
            end
            (!Load && En && state == RUN): begin
                if (ones != 4'd0) begin
                    ones_n = ones - 4'd1;
                end else begin
                    ones_n = 4'd9;
                    tens_n = tens - 4'd1;
                end
                if (at_one) begin
                    state_n = EXPIRED;
                    done_n  = 1'b1;
                end
            end
            // The reload tick restores the preset without
            // also counting it down.
            (!Load && En && state == EXPIRED && AUTO_RELOAD): begin
                tens_n  = pre_t;
                ones_n  = pre_o;
                state_n = RUN;
            end
            default: ;
        endcase
    end

    assign O_tens  = tens;
    assign O_ones  = ones;
    assign Done    = done;
    assign Running = (state == RUN);
    assign Zero    = (tens == 4'd0) && (ones == 4'd0);

endmodule

// File: tb/tb_bcd_countdown_2digit.sv
// Bench for bcd_countdown_2digit: both AUTO_RELOAD settings
// side by side, directed vectors plus a per-cycle model check.
module tb_bcd_countdown_2digit;

    logic       Clk = 1'b0;
    logic       R = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] Din = 8'h00;
    logic       En = 1'b0;

    logic [3:0] ot [2];
    logic [3:0] oo [2];
    logic       run [2];
    logic       zer [2];
    logic       dn [2];

    int passed = 0;
    int total = 0;
    bit chk_en = 1'b0;

    // Model: count as plain integer 0..99, mode 0=idle 1=run 2=expired
    int m_cnt [2];
    int m_pre [2];
    int m_mode [2];
    bit m_done [2];
    bit prev_done [2];

    always #5 Clk = ~Clk;

    bcd_countdown_2digit #(.AUTO_RELOAD(1'b0)) u0 (
        .Clk(Clk), .R(R), .Load(Load), .Din(Din), .En(En),
        .O_tens(ot[0]), .O_ones(oo[0]), .Running(run[0]),
        .Zero(zer[0]), .Done(dn[0])
    );

    bcd_countdown_2digit #(.AUTO_RELOAD(1'b1)) u1 (
        .Clk(Clk), .R(R), .Load(Load), .Din(Din), .En(En),
        .O_tens(ot[1]), .O_ones(oo[1]), .Running(run[1]),
        .Zero(zer[1]), .Done(dn[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                      name, act, exp, $time);
    endtask

    function automatic int oval(input int i);
        return int'(ot[i]) * 10 + int'(oo[i]);
    endfunction

    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            int t, o;
            t = (Din[7:4] > 9) ? 9 : int'(Din[7:4]);
            o = (Din[3:0] > 9) ? 9 : int'(Din[3:0]);
            m_done[i] = 1'b0;
            if (R) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
                m_mode[i] = 0;
            end else if (Load) begin
                m_cnt[i] = t * 10 + o;
                m_pre[i] = m_cnt[i];
                m_mode[i] = (m_cnt[i] != 0) ? 1 : 0;
            end else if (En && m_mode[i] == 1) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    m_mode[i] = 2;
                    m_done[i] = 1'b1;
                end
            end else if (En && m_mode[i] == 2 && i == 1) begin
                m_cnt[i] = m_pre[i];
                m_mode[i] = 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cnt%0d", i), oval(i), m_cnt[i]);
                chk($sformatf("bcd%0d", i),
                    int'(ot[i] <= 9 && oo[i] <= 9), 1);
                chk($sformatf("zero%0d", i), int'(zer[i]),
                    int'(m_cnt[i] == 0));
                chk($sformatf("running%0d", i), int'(run[i]),
                    int'(m_mode[i] == 1));
                chk($sformatf("done%0d", i), int'(dn[i]),
                    int'(m_done[i]));
                chk($sformatf("done_twice%0d", i),
                    int'(dn[i] && prev_done[i]), 0);
                prev_done[i] = dn[i];
            end
        end
    end

    // Inputs change at a negedge; outputs are looked at one
    // full cycle later, after the intervening rising edge.
    task automatic step(input bit r, input bit l,
                        input logic [7:0] d, input bit e);
        R = r;
        Load = l;
        Din = d;
        En = e;
        @(negedge Clk);
    endtask

    task automatic lit(input string name, input int i, input int v);
        chk({name, "_val"}, oval(i), v);
    endtask

    initial begin
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        @(negedge Clk);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk_en = 1'b1;
        lit("rst0", 0, 0);
        chk("rst_zero", int'(zer[0]), 1);
        chk("rst_run", int'(run[1]), 0);
        chk("rst_done", int'(dn[0]), 0);
        repeat (5) step(0, 0, 8'h00, 1);
        lit("idle_en", 0, 0);
        lit("idle_en1", 1, 0);

        step(0, 1, 8'h12, 0);
        lit("load12", 0, 12);
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 8'h00, 1);
            lit($sformatf("tick%0d", k), 0, 12 - k);
            if (k == 3) chk("borrow_ones", int'(oo[0]), 9);
        end
        chk("exp_done0", int'(dn[0]), 1);
        chk("exp_done1", int'(dn[1]), 1);
        chk("exp_run0", int'(run[0]), 0);
        step(0, 0, 8'h00, 1);
        lit("hold00", 0, 0);
        chk("hold_done", int'(dn[0]), 0);
        lit("autoreload", 1, 12);
        chk("autoreload_run", int'(run[1]), 1);

        step(0, 1, 8'hAF, 1);
        lit("clamp99", 0, 99);
        step(0, 0, 8'h00, 1);
        lit("dec98", 0, 98);
        step(0, 1, 8'h00, 0);
        lit("load00", 0, 0);
        chk("load00_run", int'(run[0]), 0);
        chk("load00_done", int'(dn[0]), 0);

        step(0, 1, 8'h05, 0);
        lit("gap05", 0, 5);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        lit("gap_hold", 0, 5);
        step(0, 0, 8'h00, 1);
        lit("gap04", 0, 4);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        lit("gap_hold2", 0, 4);
        step(0, 0, 8'h00, 1);
        lit("gap03", 0, 3);
        step(1, 0, 8'h00, 1);
        lit("abort", 0, 0);
        chk("abort_done", int'(dn[0]), 0);
        chk("abort_run", int'(run[0]), 0);

        step(0, 1, 8'h20, 0);
        repeat (4) step(0, 0, 8'h00, 1);
        lit("mid16", 0, 16);
        step(0, 1, 8'h03, 0);
        lit("reload03", 0, 3);
        chk("reload_run", int'(run[0]), 1);
        repeat (3) step(0, 0, 8'h00, 1);
        lit("ar_zero", 1, 0);
        chk("ar_done", int'(dn[1]), 1);
        step(0, 0, 8'h00, 1);
        lit("ar_reload", 1, 3);
        chk("ar_run", int'(run[1]), 1);
        chk("ar_nodone", int'(dn[1]), 0);
        lit("noar_hold", 0, 0);

        for (int n = 0; n < 1000; n++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) == 0,
                 8'($urandom),
                 $urandom_range(0, 1) == 1);
        end

        step(0, 0, 8'h00, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
